// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants, FSM state type and the frame builder for
//                the UART packet transmit sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Start + 8 data + parity + stop
    localparam int   FRAME_BITS = 11;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Frame bit 0 goes out first: start, data LSB first, even parity, stop.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        build_frame = {STOP_BIT, ^data, data, START_BIT};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_timer
//  Description : Free-running bit-period counter. Held at zero while clear is
//                high; tick pulses in the last cycle of every CLKS_PER_BIT
//                cycle period.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int                 c_cnt_w    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_terminal = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_count;
    logic               w_at_terminal;

    assign w_at_terminal = (r_count == c_terminal);
    assign tick          = !clear && w_at_terminal;

    // Count cycles within the current bit period, wrapping at terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear || w_at_terminal) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sequencer
//  Description : Accepts a PACKET_SIZE-bit packet, splits it into bytes (MSB
//                byte first, zero-padded at the LSB end) and transmits each
//                as an 11-bit UART frame with even parity, back to back.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int PACKET_SIZE  = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PACKET_SIZE-1:0] sys_packet,
    input  logic                   pkt_valid,
    output logic                   pkt_ready,
    input  logic                   abort,
    output logic                   tx,
    output logic                   busy,
    output logic                   done
);

    localparam int                  c_num_bytes = (PACKET_SIZE + 7) / 8;
    localparam int                  c_ext_w     = c_num_bytes * 8;
    localparam int                  c_pad       = c_ext_w - PACKET_SIZE;
    localparam int                  c_byte_w    = $clog2(c_num_bytes + 1);
    localparam logic [c_byte_w-1:0] c_last_byte = c_byte_w'(c_num_bytes - 1);
    localparam logic [3:0]          c_last_bit  = 4'(FRAME_BITS - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [c_ext_w-1:0]    r_packet;
    logic [c_byte_w-1:0]   r_byte_idx;
    logic [3:0]            r_bit_idx;
    logic                  r_tx;
    logic                  r_ready;

    logic                  w_tick;
    logic                  w_timer_clr;
    logic                  w_accept;
    logic                  w_abort;
    logic                  w_frame_end;
    logic                  w_last_byte;
    logic [c_ext_w-1:0]    w_packet_shifted;
    logic [7:0]            w_cur_byte;
    logic [FRAME_BITS-1:0] w_frame;

    // The timer only runs while a frame is on the line so every frame bit
    // starts a fresh period right after the accept edge.
    assign w_timer_clr = (r_state != SHIFT);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_timer_clr),
        .tick  (w_tick)
    );

    // Byte 0 is the most significant byte of the padded packet.
    assign w_packet_shifted = r_packet << {r_byte_idx, 3'b000};
    assign w_cur_byte       = w_packet_shifted[c_ext_w-1 -: 8];
    assign w_frame          = build_frame(w_cur_byte);
    assign w_last_byte      = (r_byte_idx == c_last_byte);

    assign pkt_ready = r_ready;
    assign tx        = r_tx;
    assign busy      = (r_state == SHIFT);
    assign done      = (r_state == FINISH);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and datapath strobes; abort only matters mid-packet
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_abort      = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            IDLE: begin
                if (pkt_valid && r_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end else if (w_tick && (r_bit_idx == c_last_bit)) begin
                    w_frame_end = 1'b1;
                    if (w_last_byte) begin
                        w_state_next = FINISH;
                    end
                end
            end
            FINISH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Packet capture, byte/bit counters and the registered serial output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_packet   <= '0;
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
            r_tx       <= STOP_BIT;
            r_ready    <= 1'b0;
        end else begin
            // Ready is registered so it stays low through reset and rises
            // one cycle after release; otherwise it tracks IDLE exactly.
            r_ready <= (w_state_next == IDLE);
            if (w_accept) begin
                r_packet   <= c_ext_w'(sys_packet) << c_pad;
                r_byte_idx <= '0;
                r_bit_idx  <= '0;
                r_tx       <= START_BIT;
            end else if (w_abort) begin
                r_byte_idx <= '0;
                r_bit_idx  <= '0;
                r_tx       <= STOP_BIT;
            end else if (w_frame_end) begin
                r_bit_idx <= '0;
                if (w_last_byte) begin
                    r_byte_idx <= '0;
                    r_tx       <= STOP_BIT;
                end else begin
                    r_byte_idx <= r_byte_idx + 1'b1;
                    r_tx       <= START_BIT;
                end
            end else if ((r_state == SHIFT) && w_tick) begin
                r_bit_idx <= r_bit_idx + 4'd1;
                r_tx      <= w_frame[r_bit_idx + 4'd1];
            end
        end
    end

endmodule
`default_nettype wire
